// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the BE prefetch dispatch arbiter
package bp_be_pkg;

    localparam int pda_vaddr_width_lp = 39;
    localparam int pda_age_width_lp   = 8;

    typedef enum logic [1:0] {
        e_pda_idle,
        e_pda_active,
        e_pda_drain
    } bp_be_pda_state_e;

    typedef struct packed {
        logic [pda_vaddr_width_lp-1:0] pc;
        logic [pda_vaddr_width_lp-1:0] vaddr;
        logic [pda_age_width_lp-1:0]   age;
    } bp_be_pref_hint_s;

endpackage

// File: rtl/bp_be_pref_hint_fifo.sv
// rtl/bp_be_pref_hint_fifo.sv - circular prefetch hint buffer with per-entry age
module bp_be_pref_hint_fifo
    import bp_be_pkg::*;
#(
    parameter int els_p          = 4,
    parameter int block_offset_p = 6
)
(
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic                                         clear_i,
    input  logic                                         enq_v_i,
    input  logic [pda_vaddr_width_lp-1:0]                enq_pc_i,
    input  logic [pda_vaddr_width_lp-1:0]                enq_vaddr_i,
    input  logic                                         deq_i,
    output logic                                         head_v_o,
    output logic [pda_vaddr_width_lp-1:0]                head_pc_o,
    output logic [pda_vaddr_width_lp-1:0]                head_vaddr_o,
    output logic [pda_age_width_lp-1:0]                  head_age_o,
    output logic                                         tail_v_o,
    output logic [pda_vaddr_width_lp-block_offset_p-1:0] tail_line_o,
    output logic                                         full_o,
    output logic                                         empty_o,
    output logic [$clog2(els_p):0]                       count_o
);

    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    bp_be_pref_hint_s      mem_r [els_p];
    logic [ptr_w_lp-1:0]   wptr_r, rptr_r;
    logic [idx_w_lp-1:0]   head_idx, tail_idx;
    bp_be_pref_hint_s      head_entry, tail_entry;

    assign head_idx   = rptr_r[idx_w_lp-1:0];
    assign tail_idx   = wptr_r[idx_w_lp-1:0] - idx_w_lp'(1);
    assign head_entry = mem_r[head_idx];
    assign tail_entry = mem_r[tail_idx];

    assign empty_o = (wptr_r == rptr_r);
    assign full_o  = (wptr_r[idx_w_lp] != rptr_r[idx_w_lp])
                  && (wptr_r[idx_w_lp-1:0] == rptr_r[idx_w_lp-1:0]);
    assign count_o = wptr_r - rptr_r;

    assign head_v_o     = ~empty_o;
    assign head_pc_o    = head_entry.pc;
    assign head_vaddr_o = head_entry.vaddr;
    assign head_age_o   = head_entry.age;
    assign tail_v_o     = ~empty_o;
    assign tail_line_o  = tail_entry.vaddr[pda_vaddr_width_lp-1:block_offset_p];

    // Every slot ages each cycle; a freshly written slot overrides its age back to zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < els_p; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            for (int i = 0; i < els_p; i++) begin
                mem_r[i].age <= mem_r[i].age + pda_age_width_lp'(1);
            end
            if (deq_i) begin
                rptr_r <= rptr_r + ptr_w_lp'(1);
            end
            if (enq_v_i) begin
                mem_r[wptr_r[idx_w_lp-1:0]] <= '{pc: enq_pc_i, vaddr: enq_vaddr_i, age: '0};
                wptr_r <= wptr_r + ptr_w_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bp_be_prefetch_dispatch_arbiter.sv
// rtl/bp_be_prefetch_dispatch_arbiter.sv - injects buffered prefetch hints into empty dispatch slots
module bp_be_prefetch_dispatch_arbiter
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int fifo_els_p     = 4,
    parameter int credits_p      = 2,
    parameter int max_age_p      = 16,
    parameter int block_offset_p = 6
)
(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     main_v_i,
    input  logic                     pref_v_i,
    input  logic [vaddr_width_p-1:0] pref_pc_i,
    input  logic [vaddr_width_p-1:0] pref_vaddr_i,
    output logic                     pref_ready_and_o,
    input  logic                     pref_done_i,
    output logic                     inj_v_o,
    output logic [vaddr_width_p-1:0] inj_pc_o,
    output logic [vaddr_width_p-1:0] inj_vaddr_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     idle_o
);

    localparam int ptr_w_lp  = $clog2(fifo_els_p) + 1;
    localparam int cred_w_lp = $clog2(credits_p + 1);
    localparam int line_w_lp = vaddr_width_p - block_offset_p;
    localparam logic [pda_age_width_lp-1:0] max_age_lp = pda_age_width_lp'(max_age_p);
    localparam logic [cred_w_lp-1:0]        credits_lp = cred_w_lp'(credits_p);

    bp_be_pda_state_e       state_r, state_n;
    logic                   is_idle, is_active, is_drain;
    logic [cred_w_lp-1:0]   credits_r;
    logic                   credits_home;
    logic                   last_v_r;
    logic [line_w_lp-1:0]   last_line_r;
    logic [15:0]            drop_cnt_r;

    logic                   head_v, tail_v, fifo_full, fifo_empty;
    logic [vaddr_width_p-1:0] head_pc, head_vaddr;
    logic [pda_age_width_lp-1:0] head_age;
    logic [line_w_lp-1:0]   tail_line, head_line, pref_line;
    logic [ptr_w_lp-1:0]    fifo_count, drop_add;
    logic [16:0]            drop_sum;

    logic accept, dup, enq, inject, drain_flush, flush, age_drop, pop;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_pda_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_pda_idle:   if (enable_i)     state_n = e_pda_active;
            e_pda_active: if (!enable_i)    state_n = e_pda_drain;
            e_pda_drain:  if (credits_home) state_n = enable_i ? e_pda_active : e_pda_idle;
            default:                        state_n = e_pda_idle;
        endcase
    end

    always_comb begin
        is_idle   = 1'b0;
        is_active = 1'b0;
        is_drain  = 1'b0;
        case (state_r)
            e_pda_active: is_active = 1'b1;
            e_pda_drain:  is_drain  = 1'b1;
            default:      is_idle   = 1'b1;
        endcase
    end

    assign credits_home = (credits_r == credits_lp);
    assign pref_line    = pref_vaddr_i[vaddr_width_p-1:block_offset_p];
    assign head_line    = head_vaddr[vaddr_width_p-1:block_offset_p];

    // Accepting while enable is falling would only feed the drain flush, so hold off.
    assign pref_ready_and_o = is_active & enable_i & ~fifo_full & ~clear_i;
    assign accept           = pref_v_i & pref_ready_and_o;
    assign inject           = is_active & head_v & ~main_v_i & ~clear_i & (credits_r != '0);

    assign dup = (tail_v & (tail_line == pref_line))
               | (last_v_r & (last_line_r == pref_line))
               | (inject & (head_line == pref_line));
    assign enq = accept & ~dup;

    assign drain_flush = is_active & ~enable_i;
    assign flush       = clear_i | drain_flush;
    assign age_drop    = is_active & head_v & ~inject & ~flush & (head_age >= max_age_lp);
    assign pop         = inject | age_drop;

    // A head injected in the flush cycle leaves legitimately, so it is not a drop.
    assign drop_add = flush ? (fifo_count - ptr_w_lp'(inject)) : ptr_w_lp'(age_drop);
    assign drop_sum = {1'b0, drop_cnt_r} + 17'(drop_add);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r   <= credits_lp;
            last_v_r    <= 1'b0;
            last_line_r <= '0;
            drop_cnt_r  <= '0;
        end else begin
            case ({inject, pref_done_i})
                2'b10:   credits_r <= credits_r - cred_w_lp'(1);
                2'b01:   credits_r <= credits_r + cred_w_lp'(1);
                default: credits_r <= credits_r;
            endcase
            if (clear_i) begin
                last_v_r <= 1'b0;
            end else if (inject) begin
                last_v_r    <= 1'b1;
                last_line_r <= head_line;
            end
            drop_cnt_r <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    bp_be_pref_hint_fifo #(
        .els_p          (fifo_els_p),
        .block_offset_p (block_offset_p)
    ) hint_fifo (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .clear_i      (flush),
        .enq_v_i      (enq),
        .enq_pc_i     (pref_pc_i),
        .enq_vaddr_i  (pref_vaddr_i),
        .deq_i        (pop),
        .head_v_o     (head_v),
        .head_pc_o    (head_pc),
        .head_vaddr_o (head_vaddr),
        .head_age_o   (head_age),
        .tail_v_o     (tail_v),
        .tail_line_o  (tail_line),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    assign inj_v_o     = inject;
    assign inj_pc_o    = head_pc;
    assign inj_vaddr_o = head_vaddr;
    assign drop_cnt_o  = drop_cnt_r;
    assign idle_o      = is_idle & fifo_empty & credits_home;

    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(pref_done_i && !inject && credits_home));

    unused_drain_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(is_drain && head_v));

endmodule

// File: tb/tb_bp_be_prefetch_dispatch_arbiter.sv
// tb/tb_bp_be_prefetch_dispatch_arbiter.sv - directed self-checking bench for the prefetch arbiter
module tb_bp_be_prefetch_dispatch_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i, enable_i, clear_i, main_v_i, pref_v_i, pref_done_i;
    logic [38:0] pref_pc_i, pref_vaddr_i;
    logic        pref_ready_and_o, inj_v_o, idle_o;
    logic [38:0] inj_pc_o, inj_vaddr_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_be_prefetch_dispatch_arbiter dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .enable_i         (enable_i),
        .clear_i          (clear_i),
        .main_v_i         (main_v_i),
        .pref_v_i         (pref_v_i),
        .pref_pc_i        (pref_pc_i),
        .pref_vaddr_i     (pref_vaddr_i),
        .pref_ready_and_o (pref_ready_and_o),
        .pref_done_i      (pref_done_i),
        .inj_v_o          (inj_v_o),
        .inj_pc_o         (inj_pc_o),
        .inj_vaddr_o      (inj_vaddr_o),
        .drop_cnt_o       (drop_cnt_o),
        .idle_o           (idle_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          inj_seen;
        int          n;
        logic [15:0] d17, d18;

        reset_n_i = 1'b0; enable_i = 1'b0; clear_i = 1'b0; main_v_i = 1'b0;
        pref_v_i = 1'b0; pref_done_i = 1'b0; pref_pc_i = '0; pref_vaddr_i = '0;
        #12;
        chk("rst_inj_v", 64'(inj_v_o), 64'd0);
        chk("rst_ready", 64'(pref_ready_and_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        tick();
        reset_n_i = 1'b1;
        tick();

        // single hint injects the cycle after enqueue
        enable_i = 1'b1;
        tick();
        pref_v_i = 1'b1; pref_pc_i = 39'h400; pref_vaddr_i = 39'h8000_1000;
        smp();
        chk("t1_ready", 64'(pref_ready_and_o), 64'd1);
        chk("t1_no_bypass", 64'(inj_v_o), 64'd0);
        tick();
        pref_v_i = 1'b0;
        smp();
        chk("t1_inj_v", 64'(inj_v_o), 64'd1);
        chk("t1_inj_vaddr", 64'(inj_vaddr_o), 64'h8000_1000);
        chk("t1_inj_pc", 64'(inj_pc_o), 64'h400);
        tick();
        smp();
        chk("t1_empty", 64'(inj_v_o), 64'd0);
        tick();
        pref_done_i = 1'b1;
        tick();
        pref_done_i = 1'b0;

        // three hints, two credits
        pref_v_i = 1'b1; pref_pc_i = 39'h404; pref_vaddr_i = 39'h8000_2000;
        smp();
        chk("t2_c0_inj", 64'(inj_v_o), 64'd0);
        tick();
        pref_vaddr_i = 39'h8000_3000;
        smp();
        chk("t2_c1_inj", 64'(inj_v_o), 64'd1);
        chk("t2_c1_vaddr", 64'(inj_vaddr_o), 64'h8000_2000);
        tick();
        pref_vaddr_i = 39'h8000_4000;
        smp();
        chk("t2_c2_inj", 64'(inj_v_o), 64'd1);
        chk("t2_c2_vaddr", 64'(inj_vaddr_o), 64'h8000_3000);
        tick();
        pref_v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t2_no_credit", 64'(inj_v_o), 64'd0);
            tick();
        end
        pref_done_i = 1'b1;
        smp();
        chk("t2_done_cycle", 64'(inj_v_o), 64'd0);
        tick();
        pref_done_i = 1'b0;
        smp();
        chk("t2_third_inj", 64'(inj_v_o), 64'd1);
        chk("t2_third_vaddr", 64'(inj_vaddr_o), 64'h8000_4000);
        tick();
        pref_done_i = 1'b1;
        tick();
        tick();
        pref_done_i = 1'b0;

        // main stream owns the slot; hint ages out
        main_v_i = 1'b1;
        pref_v_i = 1'b1; pref_vaddr_i = 39'h8000_5000;
        smp();
        chk("t3_ready", 64'(pref_ready_and_o), 64'd1);
        tick();
        pref_v_i = 1'b0;
        inj_seen = 0; d17 = '0; d18 = '0;
        for (int k = 1; k <= 20; k++) begin
            smp();
            if (inj_v_o) inj_seen++;
            if (k == 17) d17 = drop_cnt_o;
            if (k == 18) d18 = drop_cnt_o;
            tick();
        end
        chk("t3_never_inj", 64'(inj_seen), 64'd0);
        chk("t3_drop_before_age", 64'(d17), 64'd0);
        chk("t3_drop_at_age", 64'(d18), 64'd1);
        chk("t3_drop_final", 64'(drop_cnt_o), 64'd1);
        main_v_i = 1'b0;

        // same cache line filtered
        pref_v_i = 1'b1; pref_vaddr_i = 39'h8000_6000;
        tick();
        pref_vaddr_i = 39'h8000_6020;
        smp();
        chk("t4_ready", 64'(pref_ready_and_o), 64'd1);
        chk("t4_inj_v", 64'(inj_v_o), 64'd1);
        chk("t4_inj_vaddr", 64'(inj_vaddr_o), 64'h8000_6000);
        tick();
        pref_v_i = 1'b0;
        smp();
        chk("t4_dup_dropped", 64'(inj_v_o), 64'd0);
        chk("t4_drop_same", 64'(drop_cnt_o), 64'd1);
        tick();
        pref_done_i = 1'b1;
        tick();
        pref_done_i = 1'b0;

        // fill, back-pressure, clear
        main_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pref_v_i = 1'b1; pref_vaddr_i = 39'h8000_7000 + 39'(i << 12);
            tick();
        end
        pref_vaddr_i = 39'h8000_B000;
        smp();
        chk("t5_full_ready", 64'(pref_ready_and_o), 64'd0);
        tick();
        pref_v_i = 1'b0;
        clear_i = 1'b1;
        smp();
        chk("t5_clear_ready", 64'(pref_ready_and_o), 64'd0);
        tick();
        clear_i = 1'b0; main_v_i = 1'b0;
        smp();
        chk("t5_drop", 64'(drop_cnt_o), 64'd5);
        chk("t5_empty", 64'(inj_v_o), 64'd0);
        tick();

        // disable with a credit outstanding
        pref_v_i = 1'b1; pref_vaddr_i = 39'h8000_C000;
        tick();
        pref_v_i = 1'b0;
        smp();
        chk("t6_inj", 64'(inj_v_o), 64'd1);
        tick();
        enable_i = 1'b0;
        smp();
        chk("t6_idle_active", 64'(idle_o), 64'd0);
        tick();
        smp();
        chk("t6_idle_drain", 64'(idle_o), 64'd0);
        chk("t6_ready_drain", 64'(pref_ready_and_o), 64'd0);
        tick();
        pref_done_i = 1'b1;
        tick();
        pref_done_i = 1'b0;
        n = 0;
        while (!idle_o && n < 8) begin
            tick();
            n++;
        end
        chk("t6_idle", 64'(idle_o), 64'd1);
        chk("t6_drain_cycles", 64'(n), 64'd1);
        chk("t6_drop", 64'(drop_cnt_o), 64'd5);

        // async reset while an inject is presented
        enable_i = 1'b1;
        tick();
        pref_v_i = 1'b1; pref_vaddr_i = 39'h8000_D000;
        tick();
        pref_v_i = 1'b0;
        #1;
        chk("t7_inj_before", 64'(inj_v_o), 64'd1);
        reset_n_i = 1'b0;
        #1;
        chk("t7_rst_inj", 64'(inj_v_o), 64'd0);
        chk("t7_rst_ready", 64'(pref_ready_and_o), 64'd0);
        chk("t7_rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("t7_rst_idle", 64'(idle_o), 64'd1);
        tick();
        reset_n_i = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
